ahb_sram_ctrl: RTL and testbench
================================

Name: ahb_sram_ctrl

Overview:
- AHB-Lite slave that converts bus transfers into single-port SRAM accesses.
- Sits directly upstream of fpga_spram and drives its A, CEN, D and BWEN; it also returns Q as HRDATA.
- Reads are zero-wait unless they follow a write. Writes are posted into their data phase.
- A read issued immediately after a write costs one wait state. Illegal transfers get a two-cycle ERROR response.

Parameters:
- ADDRWIDTH, 17, SRAM word-address width; bus byte offset is haddr[ADDRWIDTH+1:0].
- DATAWIDTH, 32, bus and SRAM data width; only 32 is supported.

Ports:
- hclk  input  1  bus clock, rising edge.
- hrst_b  input  1  asynchronous active-low reset.
- hsel  input  1  slave select.
- haddr  input  32  byte address; bits above ADDRWIDTH+1 are ignored.
- htrans  input  2  transfer type; bit 1 set means NONSEQ/SEQ.
- hwrite  input  1  1 = write.
- hsize  input  3  transfer size.
- hwdata  input  32  write data, valid in the data phase.
- hready  input  1  bus-level HREADY (HREADYIN).
- hreadyout  output  1  slave ready.
- hresp  output  2  00 = OKAY, 01 = ERROR.
- hrdata  output  32  read data.
- sram_a  output  ADDRWIDTH  SRAM word address.
- sram_cen  output  1  SRAM chip enable, active low.
- sram_d  output  32  SRAM write data.
- sram_bwen  output  4  SRAM byte write enable, active low.
- sram_q  input  32  SRAM read data; valid one cycle after a read is issued.

Behaviour:
- Clocking and reset: single clock hclk; asynchronous active-low reset hrst_b.
- Reset values: state=IDLE, hreadyout=1, hresp=00, sram_cen=1, sram_bwen=4'hF, all registered address/lane fields 0.
- Reset asserted mid-transfer aborts the transfer. No SRAM write is issued after reset assertion.
- Transfer accepted: acc = hsel & htrans[1] & hready.
- Legality: a transfer is legal when hsize<=2 and it is aligned.
  - hsize=1 requires haddr[0]=0.
  - hsize=2 requires haddr[1:0]=0.
  - Anything else is illegal.
- Byte lanes (lane_mask):
  - size0: 1 << haddr[1:0].
  - size1: haddr[1] ? 4'b1100 : 4'b0011.
  - size2: 4'b1111.
- States:
  - IDLE: no data phase pending.
  - WR: write data phase.
  - RD: read data phase; SRAM already read.
  - RDW: delayed-read wait.
  - ERR1 / ERR2: two-cycle error response.
- SRAM port usage:
  - Combinational drive of sram_*; at most one access per cycle.
  - Default: sram_cen=1, sram_bwen=4'hF.
- Accepted legal read while state is not WR:
  - Drive sram_cen=0 and sram_a=haddr[ADDRWIDTH+1:2] in the same cycle.
  - Next state: RD.
- Accepted legal write:
  - Register the word address and lane_mask. Next state: WR.
  - In WR, drive sram_cen=0, sram_a=registered address, sram_d=hwdata, sram_bwen=~lane_mask.
  - hreadyout=1 in WR.
- Read accepted while in WR (port conflict):
  - Register the read address; the write completes this cycle. Next state: RDW.
  - In RDW, hreadyout=0; issue the SRAM read from the registered address. Next state: RD.
- In RD: hreadyout=1, hrdata=sram_q (full word, all lanes), hresp=00.
- Illegal accepted transfer: no SRAM access.
  - ERR1: hreadyout=0, hresp=01.
  - ERR2: hreadyout=1, hresp=01.
- Exit from WR, RD or ERR2: if a new transfer is accepted in that cycle, go to its state as above; otherwise go to IDLE.
- Transfer not accepted (IDLE/BUSY htrans, hsel=0, or hready=0): treated as no transfer. IDLE response is OKAY with zero wait.
- hrdata outside RD: don't-care; the implementation drives sram_q.
- Write-then-read to the same address: the read returns the new data (the write completes before the delayed read is issued).

Decomposition:
- Shared package ahb_sram_pkg holds:
  - HTRANS_IDLE / BUSY / NONSEQ / SEQ.
  - HRESP_OKAY / HRESP_ERROR.
  - HSIZE_BYTE / HALF / WORD.
  - The state encoding.
- One sub-module, ahb_sram_lane_dec: combinational hsize/haddr[1:0] -> lane_mask and legal flag.
- The top module instantiates ahb_sram_lane_dec and fpga_spram is instantiated by the integrating wrapper, not inside this block.

Test Plan:
- Reset: hrst_b low mid-WR -> hreadyout=1, hresp=00, sram_cen=1, sram_bwen=F immediately; memory unchanged.
- Word write of 0xDEADBEEF to 0x10, then word read of 0x10 -> write data phase has cen=0, a=4, bwen=0; read has one wait state; hrdata=0xDEADBEEF.
- Byte writes 0x11 @0x21 and halfword 0xAABB @0x22 over a word preset to 0x00000000 -> bwen=4'b1101 then 4'b0011; readback=0xAABB1100.
- Back-to-back reads of 0x0, 0x4, 0x8 -> zero wait states; cen=0 on each address phase; data returned in order.
- Halfword at 0x03 and hsize=3 -> two cycles each of hresp=01 (hreadyout 0 then 1); no cen assertion.
- hready=0 from another slave while hsel=1/NONSEQ -> transfer ignored; sram_cen stays 1.

Source files
------------

// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings and controller state type for the SRAM slave.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdw,
        StErr1,
        StErr2
    } state_e;

endpackage

// File: rtl/ahb_sram_lane_dec.sv
// Decodes transfer size and low address bits into a byte-lane mask and a legality flag.
module ahb_sram_lane_dec
    import ahb_sram_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] lane_mask_o,
    output logic       legal_o
);

    always_comb begin
        lane_mask_o = 4'b0000;
        legal_o     = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: begin
                lane_mask_o = 4'b0001 << addr_lo_i;
                legal_o     = 1'b1;
            end
            HSIZE_HALF: begin
                lane_mask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                legal_o     = ~addr_lo_i[0];
            end
            HSIZE_WORD: begin
                lane_mask_o = 4'b1111;
                legal_o     = (addr_lo_i == 2'b00);
            end
            default: begin
                lane_mask_o = 4'b0000;
                legal_o     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave front end for a single-port SRAM: zero-wait reads, posted writes,
// one wait state for a read that collides with a write data phase.
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 hclk,
    input  logic                 hrst_b,
    input  logic                 hsel,
    input  logic [31:0]          haddr,
    input  logic [1:0]           htrans,
    input  logic                 hwrite,
    input  logic [2:0]           hsize,
    input  logic [DATAWIDTH-1:0] hwdata,
    input  logic                 hready,
    output logic                 hreadyout,
    output logic [1:0]           hresp,
    output logic [DATAWIDTH-1:0] hrdata,
    output logic [ADDRWIDTH-1:0] sram_a,
    output logic                 sram_cen,
    output logic [DATAWIDTH-1:0] sram_d,
    output logic [3:0]           sram_bwen,
    input  logic [DATAWIDTH-1:0] sram_q
);

    state_e               state_q, state_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [3:0]           lane_q, lane_d;

    logic                 acc;
    logic                 can_accept;
    logic                 legal;
    logic [3:0]           lane_mask;
    logic [ADDRWIDTH-1:0] word_addr;
    logic                 unused_bits;

    assign acc         = hsel & htrans[1] & hready;
    assign word_addr   = haddr[ADDRWIDTH+1:2];
    assign unused_bits = ^{haddr[31:ADDRWIDTH+2], htrans[0]};
    assign hrdata      = sram_q;

    ahb_sram_lane_dec u_lane_dec (
        .hsize_i    (hsize),
        .addr_lo_i  (haddr[1:0]),
        .lane_mask_o(lane_mask),
        .legal_o    (legal)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lane_d     = lane_q;
        can_accept = 1'b0;
        hreadyout  = 1'b1;
        hresp      = HRESP_OKAY;
        sram_cen   = 1'b1;
        sram_bwen  = 4'hF;
        sram_a     = addr_q;
        sram_d     = hwdata;

        unique case (state_q)
            StIdle: begin
                state_d    = StIdle;
                can_accept = 1'b1;
            end
            StWr: begin
                sram_cen   = 1'b0;
                sram_bwen  = ~lane_q;
                state_d    = StIdle;
                can_accept = 1'b1;
            end
            StRd: begin
                state_d    = StIdle;
                can_accept = 1'b1;
            end
            StRdw: begin
                hreadyout = 1'b0;
                sram_cen  = 1'b0;
                state_d   = StRd;
            end
            StErr1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = StErr2;
            end
            StErr2: begin
                hresp      = HRESP_ERROR;
                state_d    = StIdle;
                can_accept = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // New address phase; a read during a write data phase must wait for the port.
        if (can_accept && acc) begin
            if (!legal) begin
                state_d = StErr1;
            end else if (hwrite) begin
                addr_d  = word_addr;
                lane_d  = lane_mask;
                state_d = StWr;
            end else if (state_q == StWr) begin
                addr_d  = word_addr;
                state_d = StRdw;
            end else begin
                sram_cen = 1'b0;
                sram_a   = word_addr;
                state_d  = StRd;
            end
        end
    end

    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            state_q <= StIdle;
            addr_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl with a behavioural single-port SRAM attached.
module tb_ahb_sram_ctrl;

    logic        hclk = 1'b0;
    logic        hrst_b;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hready_en;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic [16:0] sram_a;
    logic        sram_cen;
    logic [31:0] sram_d;
    logic [3:0]  sram_bwen;
    logic [31:0] sram_q;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [64];
    logic        mem_ready = 1'b0;

    always #5 hclk = ~hclk;

    // Single slave on the bus; hready_en models another slave stalling the bus.
    assign hready = hreadyout & hready_en;

    ahb_sram_ctrl dut (
        .hclk     (hclk),
        .hrst_b   (hrst_b),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hwdata   (hwdata),
        .hready   (hready),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .hrdata   (hrdata),
        .sram_a   (sram_a),
        .sram_cen (sram_cen),
        .sram_d   (sram_d),
        .sram_bwen(sram_bwen),
        .sram_q   (sram_q)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       init_word = 32'h0123_4567;
            1:       init_word = 32'h89AB_CDEF;
            2:       init_word = 32'hCAFE_F00D;
            default: init_word = 32'h0000_0000;
        endcase
    endfunction

    always @(posedge hclk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (!sram_cen) begin
            if (sram_bwen != 4'hF) begin
                for (int b = 0; b < 4; b++)
                    if (!sram_bwen[b]) mem[sram_a[5:0]][8*b +: 8] <= sram_d[8*b +: 8];
            end else begin
                sram_q <= mem[sram_a[5:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic ap(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr);
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
    endtask

    task automatic ap_idle();
        ap(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    endtask

    initial begin
        hrst_b    = 1'b0;
        hready_en = 1'b1;
        hwdata    = 32'h0;
        sram_q    = 32'h0;
        ap_idle();

        // Reset values
        repeat (3) step();
        check("rst_hreadyout", {31'b0, hreadyout}, 32'h1);
        check("rst_hresp", {30'b0, hresp}, 32'h0);
        check("rst_cen", {31'b0, sram_cen}, 32'h1);
        check("rst_bwen", {28'b0, sram_bwen}, 32'hF);
        hrst_b = 1'b1;

        // Reset asserted during a write data phase
        step();
        ap(1'b1, 2'b10, 1'b1, 3'd2, 32'h40);
        step();
        ap_idle();
        hwdata = 32'h5555_5555;
        #1;
        check("midwr_cen_before", {31'b0, sram_cen}, 32'h0);
        hrst_b = 1'b0;
        #1;
        check("midwr_cen", {31'b0, sram_cen}, 32'h1);
        check("midwr_bwen", {28'b0, sram_bwen}, 32'hF);
        check("midwr_hreadyout", {31'b0, hreadyout}, 32'h1);
        check("midwr_hresp", {30'b0, hresp}, 32'h0);
        step();
        check("midwr_mem", mem[16], 32'h0);
        hrst_b = 1'b1;

        // Word write then read of the same address
        step();
        ap(1'b1, 2'b10, 1'b1, 3'd2, 32'h10);
        #1;
        check("ww_ap_hreadyout", {31'b0, hreadyout}, 32'h1);
        step();
        ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h10);
        hwdata = 32'hDEAD_BEEF;
        #1;
        check("ww_cen", {31'b0, sram_cen}, 32'h0);
        check("ww_a", {15'b0, sram_a}, 32'h4);
        check("ww_bwen", {28'b0, sram_bwen}, 32'h0);
        check("ww_d", sram_d, 32'hDEAD_BEEF);
        step();
        ap_idle();
        #1;
        check("rdw_hreadyout", {31'b0, hreadyout}, 32'h0);
        check("rdw_cen", {31'b0, sram_cen}, 32'h0);
        check("rdw_a", {15'b0, sram_a}, 32'h4);
        step();
        check("rd_hreadyout", {31'b0, hreadyout}, 32'h1);
        check("rd_hresp", {30'b0, hresp}, 32'h0);
        check("rd_hrdata", hrdata, 32'hDEAD_BEEF);

        // Byte and halfword writes merged over a zeroed word
        step();
        ap(1'b1, 2'b10, 1'b1, 3'd2, 32'h20);
        step();
        hwdata = 32'h0;
        ap(1'b1, 2'b10, 1'b1, 3'd0, 32'h21);
        #1;
        check("bw_zero_bwen", {28'b0, sram_bwen}, 32'h0);
        step();
        hwdata = 32'h0000_1100;
        ap(1'b1, 2'b11, 1'b1, 3'd1, 32'h22);
        #1;
        check("bw_byte_bwen", {28'b0, sram_bwen}, 32'hD);
        check("bw_byte_a", {15'b0, sram_a}, 32'h8);
        step();
        hwdata = 32'hAABB_0000;
        ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h20);
        #1;
        check("bw_half_bwen", {28'b0, sram_bwen}, 32'h3);
        step();
        ap_idle();
        #1;
        check("bw_rdw_hreadyout", {31'b0, hreadyout}, 32'h0);
        step();
        check("bw_readback", hrdata, 32'hAABB_1100);

        // Back-to-back reads, zero wait
        step();
        ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h0);
        #1;
        check("b2b_cen0", {31'b0, sram_cen}, 32'h0);
        check("b2b_a0", {15'b0, sram_a}, 32'h0);
        check("b2b_rdy0", {31'b0, hreadyout}, 32'h1);
        step();
        ap(1'b1, 2'b11, 1'b0, 3'd2, 32'h4);
        #1;
        check("b2b_cen1", {31'b0, sram_cen}, 32'h0);
        check("b2b_a1", {15'b0, sram_a}, 32'h1);
        check("b2b_rdy1", {31'b0, hreadyout}, 32'h1);
        check("b2b_data0", hrdata, 32'h0123_4567);
        step();
        ap(1'b1, 2'b11, 1'b0, 3'd2, 32'h8);
        #1;
        check("b2b_a2", {15'b0, sram_a}, 32'h2);
        check("b2b_rdy2", {31'b0, hreadyout}, 32'h1);
        check("b2b_data1", hrdata, 32'h89AB_CDEF);
        step();
        ap_idle();
        #1;
        check("b2b_rdy3", {31'b0, hreadyout}, 32'h1);
        check("b2b_data2", hrdata, 32'hCAFE_F00D);

        // Illegal transfers: misaligned halfword, then hsize=3
        step();
        ap(1'b1, 2'b10, 1'b0, 3'd1, 32'h3);
        #1;
        check("err_a_cen_ap", {31'b0, sram_cen}, 32'h1);
        step();
        ap_idle();
        #1;
        check("err_a_e1_rdy", {31'b0, hreadyout}, 32'h0);
        check("err_a_e1_resp", {30'b0, hresp}, 32'h1);
        check("err_a_e1_cen", {31'b0, sram_cen}, 32'h1);
        step();
        ap(1'b1, 2'b10, 1'b0, 3'd3, 32'h0);
        #1;
        check("err_a_e2_rdy", {31'b0, hreadyout}, 32'h1);
        check("err_a_e2_resp", {30'b0, hresp}, 32'h1);
        check("err_b_cen_ap", {31'b0, sram_cen}, 32'h1);
        step();
        ap_idle();
        #1;
        check("err_b_e1_rdy", {31'b0, hreadyout}, 32'h0);
        check("err_b_e1_resp", {30'b0, hresp}, 32'h1);
        check("err_b_e1_cen", {31'b0, sram_cen}, 32'h1);
        step();
        check("err_b_e2_rdy", {31'b0, hreadyout}, 32'h1);
        check("err_b_e2_resp", {30'b0, hresp}, 32'h1);
        step();
        check("err_idle_resp", {30'b0, hresp}, 32'h0);

        // Bus stalled by another slave: the address phase must be ignored
        hready_en = 1'b0;
        ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h4);
        #1;
        check("stall_rd_cen", {31'b0, sram_cen}, 32'h1);
        step();
        ap(1'b1, 2'b10, 1'b1, 3'd2, 32'hC);
        #1;
        check("stall_cen_after_rd", {31'b0, sram_cen}, 32'h1);
        check("stall_rdy", {31'b0, hreadyout}, 32'h1);
        step();
        hready_en = 1'b1;
        ap_idle();
        hwdata = 32'hFFFF_FFFF;
        #1;
        check("stall_cen_after_wr", {31'b0, sram_cen}, 32'h1);
        check("stall_resp", {30'b0, hresp}, 32'h0);
        step();
        check("stall_mem", mem[3], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
